dmem_responder: RTL and testbench

Data-side responder for the single-cycle ARM core: it sits at the far end of the core's data-memory interface (address = ALUResult, WriteData, MemWrite out; ReadData in). It serves a word-addressed RAM plus a small set of memory-mapped peripherals:
- an LED register
- a free-running cycle counter
- a transmit FIFO whose head is drained by an external consumer through a valid/ready handshake

Reads are combinational, so the core sees ReadData in the same cycle. Writes commit on the rising clock edge.

---
 rtl/dmem_pkg.sv | 43 ++++
 rtl/sync_fifo.sv | 56 +++++
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared address map, STATUS layout and address decode for the data-side responder.
package dmem_pkg;

    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] RAM_TOP     = 32'h0000_00FC;
    localparam logic [31:0] ADDR_LED    = 32'h0000_0100;
    localparam logic [31:0] ADDR_CYCLES = 32'h0000_0104;
    localparam logic [31:0] ADDR_TXDATA = 32'h0000_0108;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_010C;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_OVF_BIT   = 1;
    localparam int STATUS_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_LED,
        REG_CYCLES,
        REG_TXDATA,
        REG_STATUS,
        REG_NONE
    } region_e;

    // Byte address in, region out; the low two address bits never affect the result.
    function automatic region_e decode_region(input logic [31:0] addr, input int ram_words);
        logic [31:0] w_off;
        region_e     w_reg;
        w_off = addr - RAM_BASE;
        w_reg = REG_NONE;
        if ((w_off <= (RAM_TOP - RAM_BASE + 32'd3)) && ((w_off >> 2) < 32'(ram_words)))
            w_reg = REG_RAM;
        else if (addr[31:2] == ADDR_LED[31:2])
            w_reg = REG_LED;
        else if (addr[31:2] == ADDR_CYCLES[31:2])
            w_reg = REG_CYCLES;
        else if (addr[31:2] == ADDR_TXDATA[31:2])
            w_reg = REG_TXDATA;
        else if (addr[31:2] == ADDR_STATUS[31:2])
            w_reg = REG_STATUS;
        return w_reg;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is only accepted when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, LED register, free-running cycle counter and a transmit FIFO.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  led,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]        r_rst_sync;
    logic              w_rst_n;
    logic              w_cnt_rst_n;
    logic [31:0]       r_ram [RAM_WORDS];
    logic [7:0]        r_led;
    logic [31:0]       r_cycles;
    logic              r_overflow;
    region_e           w_region;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_wr_ram;
    logic              w_wr_led;
    logic              w_wr_cycles;
    logic              w_push;
    logic              w_wr_status;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [31:0]       w_dout;
    logic [31:0]       w_status;

    // Assert asynchronously, release through two flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_rst_sync <= 2'b00;
        else
            r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];
    // The counter leaves reset one stage early so its first increment lands on the second edge after release.
    assign w_cnt_rst_n = r_rst_sync[0];

    assign w_region    = decode_region(Addr, RAM_WORDS);
    assign w_ram_idx   = Addr[RAM_AW+1:2];
    assign w_wr_ram    = MemWrite && (w_region == REG_RAM);
    assign w_wr_led    = MemWrite && (w_region == REG_LED);
    assign w_wr_cycles = MemWrite && (w_region == REG_CYCLES);
    assign w_push      = MemWrite && (w_region == REG_TXDATA);
    assign w_wr_status = MemWrite && (w_region == REG_STATUS);
    assign w_pop       = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (w_wr_ram)
            r_ram[w_ram_idx] <= WriteData;
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_led      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_led)
                r_led <= WriteData[7:0];
            if (w_push && w_full && !w_pop)
                r_overflow <= 1'b1;
            else if (w_wr_status && WriteData[STATUS_OVF_BIT])
                r_overflow <= 1'b0;
        end
    end

    // A write zeroes the counter and that same edge counts, so the next read sees 1.
    always_ff @(posedge clk or negedge w_cnt_rst_n) begin
        if (!w_cnt_rst_n)
            r_cycles <= '0;
        else if (w_wr_cycles)
            r_cycles <= 32'd1;
        else
            r_cycles <= r_cycles + 32'd1;
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_txfifo (
        .clk   (clk),
        .reset (w_rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (WriteData),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign led      = r_led;
    assign tx_valid = !w_empty;
    assign tx_data  = w_empty ? 32'd0 : w_dout;

    always_comb begin
        w_status = '0;
        w_status[STATUS_COUNT_LSB +: 8] = 8'(w_count);
        w_status[STATUS_OVF_BIT]        = r_overflow;
        w_status[STATUS_FULL_BIT]       = w_full;
    end

    always_comb begin
        ReadData = '0;
        case (w_region)
            REG_RAM:    ReadData = r_ram[w_ram_idx];
            REG_LED:    ReadData = {24'b0, r_led};
            REG_CYCLES: ReadData = r_cycles;
            REG_STATUS: ReadData = w_status;
            default:    ReadData = '0;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table for the memory map and FIFO order, hand sequences for the rest.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  led;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_tests;
    int n_fail;

    dmem_responder #(
        .RAM_WORDS  (64),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .led       (led),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rdy;
        logic        chk_rd;
        logic [31:0] rd;
        logic [7:0]  led;
        logic        valid;
        logic [31:0] td;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                input logic rdy, input logic chk_rd, input logic [31:0] rd,
                                input logic [7:0] l, input logic v, input logic [31:0] td);
        vec_t r;
        r.we = we; r.addr = addr; r.wd = wd; r.rdy = rdy; r.chk_rd = chk_rd;
        r.rd = rd; r.led = l; r.valid = v; r.td = td;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then settle before sampling.
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
        @(negedge clk);
        MemWrite  = we;
        Addr      = a;
        WriteData = wd;
        tx_ready  = rdy;
        #1;
    endtask

    logic [31:0] c_a;
    logic [31:0] c_b;

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = mk(1, 32'h000, 32'h1234_5678, 0, 0, 32'h0,         8'h00, 0, 32'h0);
        vecs[1]  = mk(1, 32'h040, 32'hDEAD_BEEF, 0, 0, 32'h0,         8'h00, 0, 32'h0);
        vecs[2]  = mk(0, 32'h040, 32'h0,         0, 1, 32'hDEAD_BEEF, 8'h00, 0, 32'h0);
        vecs[3]  = mk(0, 32'h043, 32'h0,         0, 1, 32'hDEAD_BEEF, 8'h00, 0, 32'h0);
        vecs[4]  = mk(1, 32'h100, 32'h0000_01A5, 0, 1, 32'h0,         8'h00, 0, 32'h0);
        vecs[5]  = mk(0, 32'h100, 32'h0,         0, 1, 32'h0000_00A5, 8'hA5, 0, 32'h0);
        vecs[6]  = mk(0, 32'h200, 32'h0,         0, 1, 32'h0,         8'hA5, 0, 32'h0);
        vecs[7]  = mk(1, 32'h200, 32'hFFFF_FFFF, 0, 1, 32'h0,         8'hA5, 0, 32'h0);
        vecs[8]  = mk(0, 32'h100, 32'h0,         0, 1, 32'h0000_00A5, 8'hA5, 0, 32'h0);
        vecs[9]  = mk(0, 32'h000, 32'h0,         0, 1, 32'h1234_5678, 8'hA5, 0, 32'h0);
        vecs[10] = mk(0, 32'h040, 32'h0,         0, 1, 32'hDEAD_BEEF, 8'hA5, 0, 32'h0);
        vecs[11] = mk(1, 32'h108, 32'h1,         0, 0, 32'h0,         8'hA5, 0, 32'h0);
        vecs[12] = mk(1, 32'h108, 32'h2,         0, 0, 32'h0,         8'hA5, 1, 32'h1);
        vecs[13] = mk(1, 32'h108, 32'h3,         0, 0, 32'h0,         8'hA5, 1, 32'h1);
        vecs[14] = mk(0, 32'h10C, 32'h0,         0, 1, 32'h0000_0300, 8'hA5, 1, 32'h1);
        vecs[15] = mk(0, 32'h108, 32'h0,         0, 1, 32'h0,         8'hA5, 1, 32'h1);
        vecs[16] = mk(0, 32'h10C, 32'h0,         1, 1, 32'h0000_0300, 8'hA5, 1, 32'h1);
        vecs[17] = mk(0, 32'h10C, 32'h0,         1, 1, 32'h0000_0200, 8'hA5, 1, 32'h2);
        vecs[18] = mk(0, 32'h10C, 32'h0,         1, 1, 32'h0000_0100, 8'hA5, 1, 32'h3);
        vecs[19] = mk(0, 32'h10C, 32'h0,         1, 1, 32'h0,         8'hA5, 0, 32'h0);
        vecs[20] = mk(0, 32'h10C, 32'h0,         0, 1, 32'h0,         8'hA5, 0, 32'h0);

        reset = 1'b0; MemWrite = 1'b0; Addr = 32'h100; WriteData = '0; tx_ready = 1'b0;
        #1;
        chk("rst led", {24'b0, led}, 32'h0);
        chk("rst tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("rst tx_data", tx_data, 32'h0);
        chk("rst read led", ReadData, 32'h0);
        Addr = 32'h104; #1;
        chk("rst cycles", ReadData, 32'h0);
        Addr = 32'h10C; #1;
        chk("rst status", ReadData, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].rdy);
            if (vecs[i].chk_rd)
                chk($sformatf("vec%0d rdata", i), ReadData, vecs[i].rd);
            chk($sformatf("vec%0d led", i), {24'b0, led}, {24'b0, vecs[i].led});
            chk($sformatf("vec%0d tx_valid", i), {31'b0, tx_valid}, {31'b0, vecs[i].valid});
            chk($sformatf("vec%0d tx_data", i), tx_data, vecs[i].td);
        end

        // Fill past full with no consumer: word 9 must be dropped and overflow set.
        for (int i = 0; i < 9; i++)
            step(1, 32'h108, 32'h100 + i, 0);
        step(0, 32'h10C, 0, 0);
        chk("full status", ReadData, 32'h0000_0803);
        chk("full head", tx_data, 32'h100);
        step(1, 32'h108, 32'hAAAA, 1);
        step(0, 32'h10C, 0, 0);
        chk("push+pop status", ReadData, 32'h0000_0803);
        chk("push+pop head", tx_data, 32'h101);
        for (int i = 0; i < 8; i++) begin
            step(0, 32'h10C, 0, 1);
            chk($sformatf("drain%0d", i), tx_data, (i < 7) ? (32'h101 + i) : 32'hAAAA);
        end
        step(0, 32'h10C, 0, 0);
        chk("drained status", ReadData, 32'h0000_0002);
        chk("drained valid", {31'b0, tx_valid}, 32'h0);
        step(1, 32'h10C, 32'h2, 0);
        step(0, 32'h10C, 0, 0);
        chk("ovf cleared", ReadData, 32'h0);

        step(0, 32'h104, 0, 0);
        c_a = ReadData;
        repeat (10) step(0, 32'h104, 0, 0);
        c_b = ReadData;
        chk("cycles delta", c_b - c_a, 32'd10);
        step(1, 32'h104, 32'h55, 0);
        step(0, 32'h104, 0, 0);
        chk("cycles after write", ReadData, 32'd1);
        step(0, 32'h104, 0, 0);
        chk("cycles after write+1", ReadData, 32'd2);

        for (int i = 0; i < 5; i++)
            step(1, 32'h108, 32'h200 + i, 0);
        step(1, 32'h100, 32'hFF, 0);
        step(0, 32'h10C, 0, 0);
        chk("pre-reset status", ReadData, 32'h0000_0500);
        chk("pre-reset led", {24'b0, led}, 32'hFF);
        #2;
        reset = 1'b0;
        #1;
        chk("async tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("async led", {24'b0, led}, 32'h0);
        chk("async tx_data", tx_data, 32'h0);
        chk("async status", ReadData, 32'h0);
        Addr = 32'h104; #1;
        chk("async cycles", ReadData, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("release edge1 cycles", ReadData, 32'd0);
        @(posedge clk); #1;
        chk("release edge2 cycles", ReadData, 32'd1);
        step(1, 32'h108, 32'h77, 0);
        step(0, 32'h10C, 0, 0);
        chk("post-reset push data", tx_data, 32'h77);
        chk("post-reset status", ReadData, 32'h0000_0100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
